// File: rtl/fpga_test_run_ctrl.sv
// Board-level run controller for the core test wrapper: debounced start button,
// core reset / fetch-enable sequencing, run timeout and result latching for LEDs.
module fpga_test_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES    = 250000,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned FETCH_DELAY_CYCLES = 8,
  parameter int unsigned TIMEOUT_CYCLES     = 2**26
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        btn_start_i,
  output logic        core_rst_no,
  output logic        fetch_enable_o,
  input  logic        tests_passed_i,
  input  logic        tests_failed_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic [2:0]  state_o,
  output logic [31:0] exit_value_o,
  output logic [31:0] run_cycles_o,
  output logic [7:0]  led_o
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RHW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int unsigned FDW = $clog2(FETCH_DELAY_CYCLES + 1);
  localparam int unsigned PHW = (RHW > FDW) ? RHW : FDW;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET      = 3'd1,
    S_WAIT_FETCH = 3'd2,
    S_RUN        = 3'd3,
    S_PASS       = 3'd4,
    S_FAIL       = 3'd5,
    S_TIMEOUT    = 3'd6
  } state_t;

  logic [1:0]     r_sync;
  logic           r_btn_level;
  logic [DBW-1:0] r_db_cnt;
  logic           r_start;

  state_t         r_state;
  logic [PHW-1:0] r_phase;
  logic           r_core_rst_n;
  logic           r_fetch;
  logic           r_running;
  logic [2:0]     r_res;
  logic [31:0]    r_exit;
  logic [31:0]    r_run_cycles;

  logic [32:0]    w_run_inc;
  state_t         w_run_next;

  // Accepted level resets high so a button held through reset must be released before it can start a run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync      <= 2'b00;
      r_btn_level <= 1'b1;
      r_db_cnt    <= '0;
      r_start     <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn_start_i};
      r_start <= 1'b0;
      if (r_sync[1] != r_btn_level) begin
        if (r_db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_btn_level <= r_sync[1];
          r_db_cnt    <= '0;
          r_start     <= r_sync[1];
        end else begin
          r_db_cnt <= r_db_cnt + DBW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_run_inc = {1'b0, r_run_cycles} + 33'd1;

  // Exit decision for the current RUN cycle, highest priority first.
  always_comb begin
    w_run_next = S_RUN;
    if (tests_failed_i) begin
      w_run_next = S_FAIL;
    end else if (exit_valid_i) begin
      w_run_next = (exit_value_i == 32'd0) ? S_PASS : S_FAIL;
    end else if (tests_passed_i) begin
      w_run_next = S_PASS;
    end else if (w_run_inc == 33'(TIMEOUT_CYCLES)) begin
      w_run_next = S_TIMEOUT;
    end else begin
      w_run_next = S_RUN;
    end
  end

  // Run sequencer with registered core controls; a start pulse restarts from any state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_core_rst_n <= 1'b0;
      r_fetch      <= 1'b0;
      r_running    <= 1'b0;
      r_res        <= 3'b000;
      r_exit       <= 32'd0;
      r_run_cycles <= 32'd0;
    end else if (r_start) begin
      r_state      <= S_RESET;
      r_phase      <= '0;
      r_core_rst_n <= 1'b0;
      r_fetch      <= 1'b0;
      r_running    <= 1'b0;
      r_res        <= 3'b000;
      r_exit       <= 32'd0;
      r_run_cycles <= 32'd0;
    end else begin
      case (r_state)
        S_RESET: begin
          if (r_phase == PHW'(RESET_HOLD_CYCLES - 1)) begin
            r_state      <= S_WAIT_FETCH;
            r_phase      <= '0;
            r_core_rst_n <= 1'b1;
          end else begin
            r_phase <= r_phase + PHW'(1);
          end
        end
        S_WAIT_FETCH: begin
          if (r_phase == PHW'(FETCH_DELAY_CYCLES - 1)) begin
            r_state   <= S_RUN;
            r_phase   <= '0;
            r_fetch   <= 1'b1;
            r_running <= 1'b1;
          end else begin
            r_phase <= r_phase + PHW'(1);
          end
        end
        S_RUN: begin
          if (r_run_cycles != 32'hFFFF_FFFF) begin
            r_run_cycles <= w_run_inc[31:0];
          end
          if (exit_valid_i && !tests_failed_i) begin
            r_exit <= exit_value_i;
          end
          if (w_run_next != S_RUN) begin
            r_state      <= w_run_next;
            r_fetch      <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_running    <= 1'b0;
            r_res        <= {w_run_next == S_TIMEOUT, w_run_next == S_FAIL, w_run_next == S_PASS};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign state_o        = r_state;
  assign core_rst_no    = r_core_rst_n;
  assign fetch_enable_o = r_fetch;
  assign exit_value_o   = r_exit;
  assign run_cycles_o   = r_run_cycles;
  assign led_o          = {r_exit[3:0], r_running, r_res};

endmodule
